// File: rtl/raw2rgb_frame_ctrl.sv
// Run controller for the raw2rgb demosaic path and its vga_gen timing source:
// accepts a run configuration, flushes the datapath, runs N frames and stops at a frame end.
module raw2rgb_frame_ctrl #(
  parameter int IN_PCNT      = 4,
  parameter int MAX_HRES     = 3840,
  parameter int MAX_VRES     = 2160,
  parameter int X_ACT_WID    = $clog2(MAX_HRES) + 1,
  parameter int Y_ACT_WID    = $clog2(MAX_VRES) + 1,
  parameter int FRAME_W      = 16,
  parameter int FLUSH_CYCLES = 16,
  parameter int WDOG_CYCLES  = 20000000
) (
  input  logic                 i_pclk,
  input  logic                 i_rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_pattern,
  input  logic [X_ACT_WID-1:0] cfg_hres,
  input  logic [Y_ACT_WID-1:0] cfg_vres,
  input  logic [FRAME_W-1:0]   cfg_nframes,
  input  logic                 i_stop,
  input  logic                 i_vsync,
  input  logic                 i_out_vsync,
  output logic                 o_dp_rstn,
  output logic                 o_run,
  output logic [1:0]           o_pattern,
  output logic [X_ACT_WID-1:0] o_hres,
  output logic [Y_ACT_WID-1:0] o_vres,
  output logic [FRAME_W-1:0]   o_frame_cnt,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_cfg_err,
  output logic                 o_wdog_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [FL_W-1:0]      FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [WD_W-1:0]      WDOG_LAST  = WD_W'(WDOG_CYCLES - 1);
  localparam logic [X_ACT_WID-1:0] HRES_MAX   = X_ACT_WID'(MAX_HRES);
  localparam logic [Y_ACT_WID-1:0] VRES_MAX   = Y_ACT_WID'(MAX_VRES);
  localparam logic [X_ACT_WID-1:0] PCNT_X     = X_ACT_WID'(IN_PCNT);

  logic [2:0]           state_r;
  logic [2:0]           state_nx_s;
  logic                 vs_prev_r;
  logic                 ovs_prev_r;
  logic [FL_W-1:0]      flush_cnt_r;
  logic [WD_W-1:0]      wdog_cnt_r;
  logic [FRAME_W-1:0]   nframes_r;
  logic                 stop_pend_r;
  logic                 cfg_ready_r;
  logic                 dp_rstn_r;
  logic                 run_r;
  logic [1:0]           pattern_r;
  logic [X_ACT_WID-1:0] hres_r;
  logic [Y_ACT_WID-1:0] vres_r;
  logic [FRAME_W-1:0]   frame_cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 cfg_err_r;
  logic                 wdog_err_r;

  logic                 cfg_legal_s;
  logic                 accept_s;
  logic                 reject_s;
  logic                 vs_rise_s;
  logic                 ovs_fall_s;
  logic                 active_s;
  logic                 wdog_clr_s;
  logic                 wdog_hit_s;
  logic [FRAME_W-1:0]   cnt_inc_s;
  logic                 finish_s;

  // Configuration legality check
  always_comb begin
    if ((cfg_hres == {X_ACT_WID{1'b0}}) || (cfg_vres == {Y_ACT_WID{1'b0}}) ||
        (cfg_hres > HRES_MAX) || (cfg_vres > VRES_MAX) ||
        ((cfg_hres % PCNT_X) != {X_ACT_WID{1'b0}})) begin
      cfg_legal_s = 1'b0;
    end else begin
      cfg_legal_s = 1'b1;
    end
  end

  assign accept_s   = (state_r == ST_IDLE) & cfg_valid & cfg_legal_s;
  assign reject_s   = (state_r == ST_IDLE) & cfg_valid & ~cfg_legal_s;
  assign vs_rise_s  = i_vsync & ~vs_prev_r;
  assign ovs_fall_s = ~i_out_vsync & ovs_prev_r;
  assign active_s   = (state_r == ST_ARM) | (state_r == ST_RUN);
  assign wdog_clr_s = ((state_r == ST_ARM) & vs_rise_s) | ((state_r == ST_RUN) & ovs_fall_s);
  assign wdog_hit_s = (wdog_cnt_r == WDOG_LAST) & ~wdog_clr_s;
  assign cnt_inc_s  = (frame_cnt_r == {FRAME_W{1'b1}}) ? frame_cnt_r : frame_cnt_r + {{(FRAME_W-1){1'b0}}, 1'b1};
  // A stop arriving on the same cycle as the frame end still lets that frame count.
  assign finish_s   = ((nframes_r != {FRAME_W{1'b0}}) && (cnt_inc_s == nframes_r)) | stop_pend_r | i_stop;

  // Next-state selection
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_FLUSH;
        else          state_nx_s = ST_IDLE;
      end
      ST_FLUSH: begin
        if (flush_cnt_r == FLUSH_LAST) state_nx_s = ST_ARM;
        else                           state_nx_s = ST_FLUSH;
      end
      ST_ARM: begin
        if (wdog_hit_s)     state_nx_s = ST_ERR;
        else if (vs_rise_s) state_nx_s = ST_RUN;
        else                state_nx_s = ST_ARM;
      end
      ST_RUN: begin
        if (ovs_fall_s && finish_s) state_nx_s = ST_DONE;
        else if (wdog_hit_s)        state_nx_s = ST_ERR;
        else                        state_nx_s = ST_RUN;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      ST_ERR:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, edge detectors and state-decoded registered outputs
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      vs_prev_r   <= 1'b0;
      ovs_prev_r  <= 1'b0;
      cfg_ready_r <= 1'b1;
      dp_rstn_r   <= 1'b0;
      run_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      vs_prev_r   <= i_vsync;
      ovs_prev_r  <= i_out_vsync;
      cfg_ready_r <= (state_nx_s == ST_IDLE);
      dp_rstn_r   <= (state_nx_s == ST_ARM) | (state_nx_s == ST_RUN);
      run_r       <= (state_nx_s == ST_ARM) | (state_nx_s == ST_RUN);
      busy_r      <= (state_nx_s != ST_IDLE);
      done_r      <= (state_nx_s == ST_DONE);
      cfg_err_r   <= reject_s;
    end
  end

  // Latched run configuration, counters, stop request and watchdog error
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      pattern_r   <= 2'd0;
      hres_r      <= {X_ACT_WID{1'b0}};
      vres_r      <= {Y_ACT_WID{1'b0}};
      nframes_r   <= {FRAME_W{1'b0}};
      frame_cnt_r <= {FRAME_W{1'b0}};
      flush_cnt_r <= {FL_W{1'b0}};
      wdog_cnt_r  <= {WD_W{1'b0}};
      stop_pend_r <= 1'b0;
      wdog_err_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        pattern_r   <= cfg_pattern;
        hres_r      <= cfg_hres;
        vres_r      <= cfg_vres;
        nframes_r   <= cfg_nframes;
        frame_cnt_r <= {FRAME_W{1'b0}};
      end else if ((state_r == ST_RUN) && ovs_fall_s) begin
        frame_cnt_r <= cnt_inc_s;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end

      if (state_r == ST_FLUSH) flush_cnt_r <= flush_cnt_r + {{(FL_W-1){1'b0}}, 1'b1};
      else                     flush_cnt_r <= {FL_W{1'b0}};

      if (active_s && !wdog_clr_s) wdog_cnt_r <= wdog_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
      else                         wdog_cnt_r <= {WD_W{1'b0}};

      if (!active_s)   stop_pend_r <= 1'b0;
      else if (i_stop) stop_pend_r <= 1'b1;
      else             stop_pend_r <= stop_pend_r;

      if (accept_s)                     wdog_err_r <= 1'b0;
      else if (state_nx_s == ST_ERR)    wdog_err_r <= 1'b1;
      else                              wdog_err_r <= wdog_err_r;
    end
  end

  assign cfg_ready   = cfg_ready_r;
  assign o_dp_rstn   = dp_rstn_r;
  assign o_run       = run_r;
  assign o_pattern   = pattern_r;
  assign o_hres      = hres_r;
  assign o_vres      = vres_r;
  assign o_frame_cnt = frame_cnt_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_cfg_err   = cfg_err_r;
  assign o_wdog_err  = wdog_err_r;

endmodule

// File: doc/raw2rgb_frame_ctrl.md
Name: raw2rgb_frame_ctrl

Overview:
- Run controller for the raw2rgb demosaic path and its vga_gen timing source.
- Accepts a run configuration (Bayer pattern, active resolution, frame count) over a valid/ready handshake and flushes the datapath with a held reset.
- Enables the timing generator and counts completed output frames, then stops cleanly at a frame boundary.
- Sits between the system controller and the vga_gen/raw2rgb pair; replaces bench-level frame counting and $finish sequencing.

Parameters:
- IN_PCNT, 4, raw pixels per input beat; cfg_hres must be a multiple of this.
- MAX_HRES, 3840, largest legal cfg_hres.
- MAX_VRES, 2160, largest legal cfg_vres.
- X_ACT_WID, $clog2(MAX_HRES)+1, width of cfg_hres/o_hres.
- Y_ACT_WID, $clog2(MAX_VRES)+1, width of cfg_vres/o_vres.
- FRAME_W, 16, width of frame count fields.
- FLUSH_CYCLES, 16, cycles o_dp_rstn is held low before a run (>=1).
- WDOG_CYCLES, 20000000, maximum cycles between output frame ends in RUN (>=1).

Ports:
- i_pclk  in  1  pixel clock; all logic on rising edge.
- i_rst  in  1  asynchronous active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  controller can accept a configuration.
- cfg_pattern  in  2  Bayer pattern: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.
- cfg_hres  in  X_ACT_WID  active width in pixels.
- cfg_vres  in  Y_ACT_WID  active height in lines.
- cfg_nframes  in  FRAME_W  frames to run; 0 = continuous.
- i_stop  in  1  request stop at next output frame end.
- i_vsync  in  1  vga_gen vsync, active-high.
- i_out_vsync  in  1  raw2rgb o_vsync, active-high.
- o_dp_rstn  out  1  active-low reset to vga_gen and raw2rgb.
- o_run  out  1  timing generator enable.
- o_pattern  out  2  latched pattern.
- o_hres  out  X_ACT_WID  latched width.
- o_vres  out  Y_ACT_WID  latched height.
- o_frame_cnt  out  FRAME_W  completed output frames this run.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse at normal run completion.
- o_cfg_err  out  1  one-cycle pulse when a configuration is rejected.
- o_wdog_err  out  1  sticky watchdog error.

Behaviour:
- Reset (async assert, sync release): state IDLE; cfg_ready=1; o_dp_rstn=0; o_run=0; o_pattern=0; o_hres=0; o_vres=0; o_frame_cnt=0; o_busy=0; o_done=0; o_cfg_err=0; o_wdog_err=0; edge-detect registers=0.
- Edge detection: registered copies of i_vsync and i_out_vsync. vs_rise = i_vsync & ~prev. ovs_fall = ~i_out_vsync & prev_out. Both are detected one cycle after the input edge.
- States:
  - IDLE: cfg_ready=1, o_dp_rstn=0, o_run=0. On cfg_valid&cfg_ready, validate the request.
    - Illegal if hres==0, vres==0, hres>MAX_HRES, vres>MAX_VRES, or hres%IN_PCNT!=0. Illegal: o_cfg_err pulses next cycle; stay in IDLE; latched outputs unchanged.
    - Legal: latch pattern/hres/vres/nframes; clear o_frame_cnt and o_wdog_err; go to FLUSH.
    - cfg_ready=0 in every other state.
  - FLUSH: o_dp_rstn=0 for exactly FLUSH_CYCLES cycles, then go to ARM.
  - ARM: o_dp_rstn=1, o_run=1. Wait for vs_rise, then go to RUN with the watchdog cleared. The watchdog is also active in ARM.
  - RUN: o_run=1.
    - On ovs_fall: o_frame_cnt++, saturating at all-ones; watchdog cleared.
    - If nframes!=0 and the new count==nframes, or stop_pend is set: go to DONE.
    - i_stop in ARM or RUN sets stop_pend; a stop with no run active is ignored.
    - Stop with simultaneous ovs_fall: counts that frame, then DONE.
  - DONE: one cycle; o_run=0, o_dp_rstn=0, o_done=1; go to IDLE; stop_pend cleared.
  - ERR: entered from ARM or RUN when the watchdog reaches WDOG_CYCLES. Sets o_wdog_err, o_run=0, o_dp_rstn=0, no o_done; go to IDLE next cycle. o_wdog_err stays set until the next legal configuration is accepted.
- o_pattern/o_hres/o_vres hold steady from acceptance until the next legal configuration.
- Continuous mode (nframes=0) ends only on i_stop or watchdog.
- i_rst asserted mid-run forces all reset values immediately; the datapath is held in reset via o_dp_rstn=0.

Test Plan:
- Legal config GBRG (2), 480x270, nframes=2, FLUSH_CYCLES=16 -> o_dp_rstn low exactly 16 cycles; o_run high until 2 ovs_fall seen; o_frame_cnt=2; single o_done pulse; cfg_ready returns 1.
- cfg_hres=482 with IN_PCNT=4, then cfg_vres=0, then cfg_hres=3844 -> each gives a one-cycle o_cfg_err; o_busy stays 0; o_hres unchanged.
- nframes=0, i_stop asserted mid-frame 3 -> run continues to end of frame 3; o_frame_cnt=3; o_done pulses.
- i_out_vsync held low in RUN with WDOG_CYCLES=1000 -> o_wdog_err set at the 1000th cycle; o_run=0; no o_done. The next legal config clears o_wdog_err.
- i_stop coincident with the 2nd ovs_fall, nframes=5 -> o_frame_cnt=2, DONE next cycle.
- i_rst pulsed during RUN -> all outputs return to reset values asynchronously; a new config is accepted after release.
